// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - UART boot loader that writes a framed program image into imem
//
// Frame on the serial line: SYNC_BYTE, CNT_LO, CNT_HI, 4*N data bytes (little-endian words),
// then CHK = XOR of all data bytes. The core is held in reset until a checksum-valid image lands.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   uart_rx    - serial input (8N1, idle high), asynchronous to clk
//   imem_we    - one-cycle write strobe per assembled word
//   imem_addr  - word address of the write (holds when imem_we=0)
//   imem_wdata - word being written (holds when imem_we=0)
//   cpu_reset  - 1 holds the core in reset, 0 lets it run
//   load_done  - sticky: image loaded and verified
//   load_error - framing/length/checksum error, cleared by the next SYNC_BYTE
module imem_uart_loader #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          ADDR_WIDTH   = 8,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_rx,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic                  load_error
);
   localparam int             CW        = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam int             CAPACITY  = 1 << ADDR_WIDTH;

   // ---------------- receiver ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t      rx_state, rx_state_n;
   logic [CW-1:0]  rx_cnt, rx_cnt_n;
   logic [2:0]     rx_bit, rx_bit_n;
   logic [7:0]     rx_shift, rx_shift_n;
   logic           rx_meta, rx_sync, rx_prev;
   logic           rx_stb, rx_ferr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
      end else begin
         rx_meta  <= uart_rx;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
      end
   end

   // rx_stb / rx_ferr are single-cycle pulses at the stop-bit centre.
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt + 1'b1;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_stb     = 1'b0;
      rx_ferr    = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_cnt_n = '0;
            if (rx_prev && !rx_sync) rx_state_n = RX_START;
         end
         RX_START: if (rx_cnt == HALF_LAST) begin
            rx_cnt_n   = '0;
            rx_bit_n   = '0;
            // line back high at mid-start: glitch, not a start bit
            rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt == BIT_LAST) begin
            rx_cnt_n   = '0;
            rx_shift_n = {rx_sync, rx_shift[7:1]};
            rx_bit_n   = rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
         end
         RX_STOP: if (rx_cnt == BIT_LAST) begin
            rx_state_n = RX_IDLE;
            rx_stb     = rx_sync;
            rx_ferr    = !rx_sync;
         end
         default: rx_state_n = RX_IDLE;
      endcase
   end

   // ---------------- frame parser ----------------
   typedef enum logic [2:0] {S_IDLE, S_CNT_LO, S_CNT_HI, S_DATA, S_CHK, S_DONE, S_ERROR} state_t;

   state_t                 state, state_n;
   logic [7:0]             cnt_lo, cnt_lo_n;
   logic [15:0]            word_cnt, word_cnt_n;
   logic [ADDR_WIDTH:0]    index, index_n;        // one extra bit so it can reach CAPACITY
   logic [1:0]             byte_sel, byte_sel_n;
   logic [23:0]            word_buf, word_buf_n;
   logic [7:0]             chk, chk_n;
   logic                   imem_we_n, cpu_reset_n, load_done_n, load_error_n;
   logic [ADDR_WIDTH-1:0]  imem_addr_n;
   logic [31:0]            imem_wdata_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt_lo     <= '0;
         word_cnt   <= '0;
         index      <= '0;
         byte_sel   <= '0;
         word_buf   <= '0;
         chk        <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
      end else begin
         state      <= state_n;
         cnt_lo     <= cnt_lo_n;
         word_cnt   <= word_cnt_n;
         index      <= index_n;
         byte_sel   <= byte_sel_n;
         word_buf   <= word_buf_n;
         chk        <= chk_n;
         imem_we    <= imem_we_n;
         imem_addr  <= imem_addr_n;
         imem_wdata <= imem_wdata_n;
         cpu_reset  <= cpu_reset_n;
         load_done  <= load_done_n;
         load_error <= load_error_n;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_lo_n     = cnt_lo;
      word_cnt_n   = word_cnt;
      index_n      = index;
      byte_sel_n   = byte_sel;
      word_buf_n   = word_buf;
      chk_n        = chk;
      imem_we_n    = 1'b0;
      imem_addr_n  = imem_addr;
      imem_wdata_n = imem_wdata;
      cpu_reset_n  = cpu_reset;
      load_done_n  = load_done;
      load_error_n = load_error;
      if (rx_stb) begin
         case (state)
            S_IDLE, S_ERROR: if (rx_shift == SYNC_BYTE) begin
               state_n      = S_CNT_LO;
               chk_n        = '0;
               index_n      = '0;
               byte_sel_n   = '0;
               load_error_n = 1'b0;
            end
            S_CNT_LO: begin
               cnt_lo_n = rx_shift;
               state_n  = S_CNT_HI;
            end
            S_CNT_HI: begin
               word_cnt_n = {rx_shift, cnt_lo};
               if ({rx_shift, cnt_lo} == 16'd0) begin
                  state_n = S_CHK;
               end else if ({16'd0, rx_shift, cnt_lo} > 32'(CAPACITY)) begin
                  state_n      = S_ERROR;
                  load_error_n = 1'b1;
               end else begin
                  state_n = S_DATA;
               end
            end
            S_DATA: begin
               chk_n      = chk ^ rx_shift;
               byte_sel_n = byte_sel + 1'b1;
               if (byte_sel == 2'd3) begin
                  imem_we_n    = 1'b1;
                  imem_addr_n  = index[ADDR_WIDTH-1:0];
                  imem_wdata_n = {rx_shift, word_buf};
                  index_n      = index + 1'b1;
                  if (32'(index) + 32'd1 == 32'(word_cnt)) state_n = S_CHK;
               end else begin
                  word_buf_n[8*byte_sel +: 8] = rx_shift;
               end
            end
            S_CHK: begin
               if (rx_shift == chk) begin
                  state_n     = S_DONE;
                  load_done_n = 1'b1;
                  cpu_reset_n = 1'b0;
               end else begin
                  state_n      = S_ERROR;
                  load_error_n = 1'b1;
               end
            end
            default: ;  // S_DONE: locked until reset
         endcase
      end else if (rx_ferr) begin
         // a bad stop bit only matters once a frame is in progress
         if (state == S_CNT_LO || state == S_CNT_HI || state == S_DATA || state == S_CHK) begin
            state_n      = S_ERROR;
            load_error_n = 1'b1;
         end
      end
   end
endmodule
